// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: XLEN/BITS_PER_CYCLE + 2 edges from acceptance; 2 edges for divide-by-zero/overflow.
// Backpressure: result held in DONE until resp_ready; no new request accepted until IDLE.
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int ITERS = XLEN / BPC;
    localparam int CW    = $clog2(ITERS) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4) || (XLEN % BPC) != 0) begin : g_bad_param
            $error("ex_muldiv_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;

    assign req_ready  = rst && (state_q == S_IDLE) && !flush;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != S_IDLE);

    // Operand decode, evaluated from the latched request during PREP.
    logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg    = a_signed & a_q[XLEN-1];
        b_neg    = b_signed & b_q[XLEN-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        div_zero = (b_q == '0);
        div_ovf  = is_div && a_signed && (a_q == INT_MIN) && (b_q == '1);
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [XLEN+BPC-1:0] mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [XLEN:0]       rem_w, trial;
    logic [XLEN-1:0]     quo_w;

    always_comb begin
        mul_sum = {{BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        for (int i = 0; i < BPC; i++) begin
            if (acc_q[i]) begin
                mul_sum = mul_sum + ({{BPC{1'b0}}, mcand_q} << i);
            end
        end
        mul_next = {mul_sum, acc_q[XLEN-1:BPC]};

        rem_w = {1'b0, acc_q[2*XLEN-1:XLEN]};
        quo_w = acc_q[XLEN-1:0];
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            rem_w = {rem_w[XLEN-1:0], quo_w[XLEN-1]};
            quo_w = {quo_w[XLEN-2:0], 1'b0};
            trial = rem_w - {1'b0, mcand_q};
            if (!trial[XLEN]) begin
                rem_w    = trial;
                quo_w[0] = 1'b1;
            end
        end
        div_next = {rem_w[XLEN-1:0], quo_w};
    end

    // Sign correction applied to the value produced by the final iteration.
    logic [XLEN-1:0] prod_hi, quo_res, rem_res, final_res;

    always_comb begin
        prod_hi = mul_next[2*XLEN-1:XLEN];
        if (neg_q) begin
            // High half of a 2*XLEN negation: carry in only when the low half is zero.
            prod_hi = ~prod_hi + XLEN'(mul_next[XLEN-1:0] == '0);
        end
        quo_res = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_res = neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_res = mul_next[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_hi;
            OP_DIV, OP_DIVU:              final_res = quo_res;
            default:                      final_res = rem_res;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = S_PREP;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                end
            end
            S_PREP: begin
                cnt_d   = '0;
                mcand_d = b_mag;
                acc_d   = {{XLEN{1'b0}}, a_mag};
                // Remainder follows the dividend; everything else follows the sign product.
                neg_d   = (is_div && op_q[1]) ? a_neg : (a_neg ^ b_neg);
                if (is_div && div_zero) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = op_q[1] ? a_q : '1;
                end else if (div_ovf) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = op_q[1] ? '0 : a_q;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = final_res;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            resp_data_d  = resp_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mcand_q      <= mcand_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: one instance per BITS_PER_CYCLE (1 and 4), checked against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid1, req_valid4, flush, resp_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rr1, rr4, rv1, rv4, busy1, busy4;
    logic [31:0] rd1, rd4;
    bit          use4;
    logic        rr_s, rv_s, busy_s;
    logic [31:0] rd_s;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rr_s   = use4 ? rr4 : rr1;
    assign rv_s   = use4 ? rv4 : rv1;
    assign busy_s = use4 ? busy4 : busy1;
    assign rd_s   = use4 ? rd4 : rd1;

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(rr1), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .resp_valid(rv1), .resp_ready(resp_ready),
        .resp_data(rd1), .busy(busy1)
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(rr4), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .resp_valid(rv4), .resp_ready(resp_ready),
        .resp_data(rd4), .busy(busy4)
    );

    // Reference: plain 64-bit integer arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int exp_latency(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return sel ? 10 : 34;
    endfunction

    // Issues one request and waits for resp_valid; lat counts edges with the acceptance edge as 1.
    task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_leak);
        use4 = sel; req_op = op; req_a = a; req_b = b;
        lat = -1; rdy_leak = 1'b0;
        for (int w = 0; w < 50 && !rr_s; w++) begin @(posedge clk); #1; end
        if (sel) req_valid4 = 1'b1; else req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0; req_valid4 = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (rv_s) begin lat = n; break; end
            if (rr_s) rdy_leak = 1'b1;
            @(posedge clk); #1;
        end
        if (rr_s) rdy_leak = 1'b1;
        res = rd_s;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid1 = 1'b0; req_valid4 = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0; use4 = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", rv1); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", rd1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (rr1 !== 1'b0 || rr4 !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b/%b expected 0/0", rr1, rr4); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rr1 !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", rr1); end
    endtask

    task automatic test_mul_directed(input bit sel);
        logic [2:0]  ops [4];
        logic [31:0] as [4], bs [4], exps [4];
        logic [31:0] res;
        int          lat, elat;
        bit          leak;
        ops  = '{3'd0, 3'd1, 3'd3, 3'd2};
        as   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        exps = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        elat = sel ? 10 : 34;
        for (int i = 0; i < 4; i++) begin
            run_op(sel, ops[i], as[i], bs[i], res, lat, leak);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL mul_res[bpc%0d,%0d]: got %h expected %h", sel ? 4 : 1, i, res, exps[i]); end
            checks++; if (lat != elat) begin errors++; $display("FAIL mul_lat[bpc%0d,%0d]: got %0d expected %0d", sel ? 4 : 1, i, lat, elat); end
            checks++; if (leak) begin errors++; $display("FAIL mul_req_ready_low[bpc%0d,%0d]: got 1 expected 0", sel ? 4 : 1, i); end
            consume();
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  ops [4];
        logic [31:0] as [4], bs [4], exps [4];
        logic [31:0] res;
        int          lat;
        bit          leak;
        ops  = '{3'd4, 3'd6, 3'd5, 3'd7};
        as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        bs   = '{32'd2, 32'd2, 32'd7, 32'd7};
        exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], res, lat, leak);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL div_res[%0d]: got %h expected %h", i, res, exps[i]); end
            checks++; if (lat != 34) begin errors++; $display("FAIL div_lat[%0d]: got %0d expected 34", i, lat); end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4];
        logic [31:0] as [4], bs [4], exps [4];
        logic [31:0] res;
        int          lat;
        bit          leak;
        ops  = '{3'd5, 3'd6, 3'd4, 3'd7};
        as   = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        bs   = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        exps = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h1234_5678};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], res, lat, leak);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL special_res[%0d]: got %h expected %h", i, res, exps[i]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL special_lat[%0d]: got %0d expected 2", i, lat); end
            consume();
        end
    endtask

    task automatic test_random(input bit sel, input int count);
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, elat;
        bit          leak;
        for (int i = 0; i < count; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            exp  = ref_model(op, a, b);
            elat = exp_latency(sel, op, a, b);
            run_op(sel, op, a, b, res, lat, leak);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand_res[bpc%0d,%0d] op=%0d a=%h b=%h: got %h expected %h", sel ? 4 : 1, i, op, a, b, res, exp); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand_lat[bpc%0d,%0d] op=%0d: got %0d expected %0d", sel ? 4 : 1, i, op, lat, elat); end
            checks++; if (leak) begin errors++; $display("FAIL rand_req_ready_low[bpc%0d,%0d]: got 1 expected 0", sel ? 4 : 1, i); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, exp, exp2;
        int          lat;
        bit          leak, stable;
        exp = ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        resp_ready = 1'b0;
        run_op(1'b0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, res, lat, leak);
        checks++; if (res !== exp) begin errors++; $display("FAIL bp_res: got %h expected %h", res, exp); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rv1 !== 1'b1 || rd1 !== exp || rr1 !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold: got unstable (valid=%b data=%h ready=%b) expected held", rv1, rd1, rr1); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rv1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", rv1, busy1); end
        checks++; if (rr1 !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", rr1); end
        checks++; if (rd1 !== exp) begin errors++; $display("FAIL bp_data_hold: got %h expected %h", rd1, exp); end
        req_op = 3'd7; req_a = 32'd1000; req_b = 32'd33;
        exp2 = ref_model(3'd7, 32'd1000, 32'd33);
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bp_new_accept: got busy=%b expected 1", busy1); end
        for (int n = 0; n < 60 && !rv1; n++) begin @(posedge clk); #1; end
        checks++; if (rv1 !== 1'b1 || rd1 !== exp2) begin errors++; $display("FAIL bp_new_res: got valid=%b data=%h expected 1/%h", rv1, rd1, exp2); end
        consume();
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        bit          leak, seen;
        use4 = 1'b0; resp_ready = 1'b1;
        req_op = 3'd0; req_a = 32'h0000_1234; req_b = 32'h0000_5678;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL flush_pre: got busy=%b valid=%b expected 1/0", busy1, rv1); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy1 !== 1'b0 || rv1 !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b valid=%b expected 0/0", busy1, rv1); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rv1 !== 1'b0 || busy1 !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_resp: got activity expected none"); end
        flush = 1'b1; req_valid1 = 1'b1; #1;
        checks++; if (rr1 !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready: got %b expected 0", rr1); end
        @(posedge clk); #1;
        req_valid1 = 1'b0; flush = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got busy=%b expected 0", busy1); end
        resp_ready = 1'b0;
        run_op(1'b0, 3'd5, 32'd50, 32'd0, res, lat, leak);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (rv1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL flush_done: got valid=%b busy=%b expected 0/0", rv1, busy1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          leak;
        run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, leak);
        consume();
        checks++; if (rd1 !== 32'hFFFF_FFEB) begin errors++; $display("FAIL data_hold_after_hs: got %h expected ffffffeb", rd1); end
        req_op = 3'd4; req_a = 32'd999; req_b = 32'd3;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (rv1 !== 1'b0 || rd1 !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs: got valid=%b data=%h expected 0/0", rv1, rd1); end
        checks++; if (busy1 !== 1'b0 || rr1 !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got busy=%b ready=%b expected 0/0", busy1, rr1); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rr1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_mid_recover: got ready=%b busy=%b expected 1/0", rr1, busy1); end
    endtask

    initial begin
        test_reset();
        test_mul_directed(1'b0);
        test_div_directed();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(1'b0, 60);
        test_mul_directed(1'b1);
        test_random(1'b1, 30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the execute stage.
- Sits beside the single-cycle ALU/compare path. Accepts one operation through a valid/ready request handshake and computes it over multiple cycles.
- Returns the result through a valid/ready response handshake, which the pipeline uses to stall ID/EX.
- Parametrised in datapath width and in result bits retired per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, multiplier/quotient bits retired per iteration; legal values 1, 2, 4 (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  input  XLEN  rs1 operand.
- req_b  input  XLEN  rs2 operand.
- flush  input  1  kill the in-flight operation (branch mispredict/exception).
- resp_valid  output  1  resp_data holds a result.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  XLEN  result.
- busy  output  1  state != IDLE.

Behaviour:
- ITERS = XLEN/BITS_PER_CYCLE.
- States: IDLE, PREP, BUSY, DONE. Encoding is free.
- Reset (rst low, asynchronous):
  - state=IDLE, resp_valid=0, resp_data=0, busy=0, internal counters/accumulators 0.
  - req_ready=0 while rst is low.
- req_ready = (state==IDLE) && !flush, combinational. No request is accepted in PREP, BUSY or DONE, so there is no back-to-back acceptance on the response-handshake cycle.
- Acceptance: req_valid && req_ready at a rising edge latches op, a, b and moves IDLE->PREP.
- PREP (1 cycle):
  - Takes operand absolute values per op signedness: MULH both signed, MULHSU a signed / b unsigned, MULHU/DIVU/REMU unsigned, MUL sign-agnostic.
  - Records the result sign and clears the iteration counter.
  - Division special cases skip BUSY and go PREP->DONE (total latency 2 edges):
    - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
    - Signed overflow (DIV/REM with a = 2^(XLEN-1), b = all ones): DIV result = a; REM result = 0.
  - Otherwise PREP->BUSY.
- BUSY (ITERS cycles):
  - Multiply: shift-add, BITS_PER_CYCLE multiplier bits per cycle, 2*XLEN-bit accumulator.
  - Divide: restoring, BITS_PER_CYCLE quotient bits per cycle.
  - The counter increments each cycle. On the last iteration, the sign-corrected final result is written to resp_data and the state goes BUSY->DONE.
- Result selection: MUL low XLEN of the product; MULH/MULHSU/MULHU high XLEN; DIV/DIVU quotient; REM/REMU remainder.
- Signed results: the quotient is negated iff the operand signs differ; the remainder takes the sign of a. All arithmetic is modulo 2^XLEN.
- Normal latency: acceptance edge to resp_valid rising = ITERS+2 edges (34 for the defaults).
- DONE:
  - resp_valid=1; resp_data is stable until the handshake.
  - resp_valid && resp_ready at an edge -> IDLE, resp_valid=0. resp_data holds its last value.
  - With resp_ready low the unit holds in DONE indefinitely.
- flush:
  - In any state, flush high at an edge forces IDLE and resp_valid=0; no response is produced. flush has priority over the response handshake in the same cycle.
  - flush in IDLE blocks acceptance that cycle.
- Reset mid-operation: immediate IDLE and outputs at reset values; no partial result is visible.
- Unknown values are never propagated to resp_data in DONE.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), resp_ready=1 -> resp_data=0xFFFFFFEB, resp_valid rises exactly 34 edges after acceptance, req_ready low throughout.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=0x80000000, b=0xFFFFFFFF -> 0, each with resp_valid 2 edges after acceptance.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready=0; raising resp_ready -> IDLE next edge. Then issue a new request and check acceptance.
- flush asserted at BUSY iteration 10 -> IDLE next edge, no resp_valid. Assert rst low mid-BUSY -> resp_valid=0, resp_data=0, busy=0 asynchronously. Repeat the MUL directed checks with BITS_PER_CYCLE=4 -> latency 10.
